// File: rtl/paddle_key_decoder.sv
// paddle_key_decoder: converts the PS/2 scan-code byte stream into held-key levels
// Left/Right/Turbo, with E0/F0 prefix tracking and last-pressed-wins direction priority.
`default_nettype none

module paddle_key_decoder #(
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter logic [7:0] TURBO_CODE     = 8'h29,
  parameter int         PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dinValid,
  output logic       Left,
  output logic       Right,
  output logic       Turbo,
  output logic [1:0] prefixState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]  EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  BRK_PREFIX   = 8'hF0;
  localparam logic        DIR_LEFT     = 1'b0;
  localparam logic        DIR_RIGHT    = 1'b1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(PREFIX_TIMEOUT - 1);

  state_t      state;
  logic        left_held;
  logic        right_held;
  logic        turbo_held;
  logic        last_dir;
  logic [15:0] timeout_cnt;

  assign prefixState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      left_held   <= 1'b0;
      right_held  <= 1'b0;
      turbo_held  <= 1'b0;
      last_dir    <= DIR_LEFT;
      timeout_cnt <= 16'd0;
      Left        <= 1'b0;
      Right       <= 1'b0;
      Turbo       <= 1'b0;
    end else begin
      // Outputs trail the flags by one cycle.
      Left  <= left_held & (~right_held | (last_dir == DIR_LEFT));
      Right <= right_held & (~left_held | (last_dir == DIR_RIGHT));
      Turbo <= turbo_held;

      if (dinValid) begin
        timeout_cnt <= 16'd0;
        case (state)
          IDLE: begin
            if (din == EXT_PREFIX)      state <= EXT;
            else if (din == BRK_PREFIX) state <= BRK;
            else if (din == TURBO_CODE) turbo_held <= 1'b1;
          end
          EXT: begin
            if (din == BRK_PREFIX) begin
              state <= EXT_BRK;
            end else if (din == EXT_PREFIX) begin
              state <= EXT;
            end else begin
              state <= IDLE;
              // Typematic repeats must not move the priority.
              if (din == LEFT_CODE && !left_held) begin
                left_held <= 1'b1;
                last_dir  <= DIR_LEFT;
              end else if (din == RIGHT_CODE && !right_held) begin
                right_held <= 1'b1;
                last_dir   <= DIR_RIGHT;
              end
            end
          end
          BRK: begin
            if (din == EXT_PREFIX) begin
              state <= EXT_BRK;
            end else if (din == BRK_PREFIX) begin
              state <= BRK;
            end else begin
              state <= IDLE;
              if (din == TURBO_CODE) turbo_held <= 1'b0;
            end
          end
          default: begin
            if (din == EXT_PREFIX || din == BRK_PREFIX) begin
              state <= EXT_BRK;
            end else begin
              state <= IDLE;
              if (din == LEFT_CODE)       left_held  <= 1'b0;
              else if (din == RIGHT_CODE) right_held <= 1'b0;
            end
          end
        endcase
      end else if (state == IDLE) begin
        timeout_cnt <= 16'd0;
      end else if (timeout_cnt == TIMEOUT_LAST) begin
        // Stale prefix: drop it, flags untouched.
        state       <= IDLE;
        timeout_cnt <= 16'd0;
      end else begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paddle_key_decoder.sv
// Directed self-checking bench for paddle_key_decoder (PREFIX_TIMEOUT reduced to 20).
`default_nettype none

module tb_paddle_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       dinValid;
  logic       Left;
  logic       Right;
  logic       Turbo;
  logic [1:0] prefixState;

  int pass_cnt = 0;
  int total_cnt = 0;

  paddle_key_decoder #(
    .LEFT_CODE     (8'h6B),
    .RIGHT_CODE    (8'h74),
    .TURBO_CODE    (8'h29),
    .PREFIX_TIMEOUT(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dinValid   (dinValid),
    .Left       (Left),
    .Right      (Right),
    .Turbo      (Turbo),
    .prefixState(prefixState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Strobe one byte; returns at the negedge right after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din = b;
    dinValid = 1'b1;
    @(negedge clk);
    dinValid = 1'b0;
    din = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    idle(3);
  endtask

  task automatic check_lrt(input string tag, input logic l, input logic r, input logic t);
    check({tag, ".L"}, {7'd0, Left}, {7'd0, l});
    check({tag, ".R"}, {7'd0, Right}, {7'd0, r});
    check({tag, ".T"}, {7'd0, Turbo}, {7'd0, t});
  endtask

  initial begin
    reset = 1'b1;
    din = 8'h00;
    dinValid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_lrt("reset", 1'b0, 1'b0, 1'b0);
    check("reset.st", {6'd0, prefixState}, 8'd0);

    // Press left: output two clocks after the 6B strobe.
    send_gap(8'hE0);
    check("ext.st", {6'd0, prefixState}, 8'd1);
    send(8'h6B);
    check("left.lat1", {7'd0, Left}, 8'd0);
    idle(1);
    check_lrt("left", 1'b1, 1'b0, 1'b0);
    check("left.st", {6'd0, prefixState}, 8'd0);
    idle(2);

    // Press right while left held: right wins.
    send_gap(8'hE0);
    send_gap(8'h74);
    check_lrt("both_r", 1'b0, 1'b1, 1'b0);

    // Release right: left returns exactly 2 clk after the 74.
    send_gap(8'hE0);
    send_gap(8'hF0);
    check("extbrk.st", {6'd0, prefixState}, 8'd3);
    send(8'h74);
    check("relr.lat1", {7'd0, Left}, 8'd0);
    idle(1);
    check_lrt("relr", 1'b1, 1'b0, 1'b0);
    idle(2);

    // Right again, then typematic repeat of left leaves priority alone.
    send_gap(8'hE0);
    send_gap(8'h74);
    send_gap(8'hE0);
    send_gap(8'h6B);
    check_lrt("repeat", 1'b0, 1'b1, 1'b0);

    // Release left: right still asserted; then release right.
    send_gap(8'hE0);
    send_gap(8'hF0);
    send_gap(8'h6B);
    check_lrt("rell", 1'b0, 1'b1, 1'b0);
    send_gap(8'hE0);
    send_gap(8'hF0);
    send_gap(8'h74);
    check_lrt("relall", 1'b0, 1'b0, 1'b0);

    // Turbo make/break, then keypad 4/6 codes without prefix.
    send_gap(8'h29);
    check_lrt("turbo", 1'b0, 1'b0, 1'b1);
    send_gap(8'hF0);
    check("brk.st", {6'd0, prefixState}, 8'd2);
    send_gap(8'h29);
    check_lrt("turbo_off", 1'b0, 1'b0, 1'b0);
    send_gap(8'h6B);
    send_gap(8'h74);
    check_lrt("keypad", 1'b0, 1'b0, 1'b0);
    check("keypad.st", {6'd0, prefixState}, 8'd0);

    // Prefix timeout: E0 then long silence discards it.
    send(8'hE0);
    idle(16);
    check("to.pending", {6'd0, prefixState}, 8'd1);
    idle(8);
    check("to.expired", {6'd0, prefixState}, 8'd0);
    send_gap(8'h6B);
    check_lrt("to.left", 1'b0, 1'b0, 1'b0);

    // 6B strobed 19 cycles after E0 still completes the prefix.
    send(8'hE0);
    idle(18);
    send(8'h6B);
    idle(1);
    check_lrt("to.inwin", 1'b1, 1'b0, 1'b0);
    idle(2);

    // Reset while in EXT_BRK with Left asserted.
    send_gap(8'hE0);
    send_gap(8'hF0);
    check("rst.pre_st", {6'd0, prefixState}, 8'd3);
    check("rst.pre_L", {7'd0, Left}, 8'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_lrt("rst", 1'b0, 1'b0, 1'b0);
    check("rst.st", {6'd0, prefixState}, 8'd0);
    send_gap(8'h6B);
    check_lrt("rst.6b", 1'b0, 1'b0, 1'b0);
    check("rst.6b.st", {6'd0, prefixState}, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/paddle_key_decoder.md
Name: paddle_key_decoder

Overview:
- Upstream stage of the paddle mover: turns the PS/2 keyboard byte stream into the held-key levels Left, Right and Turbo.
- Tracks the E0 (extended) and F0 (break) prefixes and keeps one "held" flag per key.
- Resolves simultaneous Left+Right with last-pressed-wins priority, so at most one direction is asserted.
- Sits between the PS/2 byte receiver and the paddle motion block.

Parameters:
- LEFT_CODE, 8'h6B, scan code of left arrow (extended, E0-prefixed).
- RIGHT_CODE, 8'h74, scan code of right arrow (extended, E0-prefixed).
- TURBO_CODE, 8'h29, scan code of space bar (non-extended).
- PREFIX_TIMEOUT, 50000, clk cycles a prefix may wait for its next byte before being discarded; range 2..65535.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- din  input  8  received scan-code byte; valid only when dinValid=1.
- dinValid  input  1  single-cycle strobe, one per received byte.
- Left  output  1  move-left request (level).
- Right  output  1  move-right request (level).
- Turbo  output  1  turbo request (level).
- prefixState  output  2  current FSM state, for debug and verification.

Behaviour:
- One clock domain; every state element and output is registered.
- Reset (sync, active-high) forces:
  - FSM to IDLE;
  - leftHeld, rightHeld, turboHeld, lastDir (LEFT), timeout counter, Left, Right, Turbo all to 0.
- Reset has priority over a dinValid in the same cycle; any partial prefix is dropped.
- FSM states, encoded on prefixState: IDLE=0, EXT=1, BRK=2, EXT_BRK=3. Bytes are processed only when dinValid=1.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - TURBO_CODE -> turboHeld=1, stay IDLE.
  - Any other byte -> ignored, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - LEFT_CODE -> leftHeld=1, go IDLE.
  - RIGHT_CODE -> rightHeld=1, go IDLE.
  - Any other byte -> IDLE, no flag change.
- BRK:
  - TURBO_CODE -> turboHeld=0, go IDLE.
  - E0 -> EXT_BRK.
  - F0 -> stay BRK.
  - Any other byte -> IDLE, no flag change.
- EXT_BRK:
  - LEFT_CODE -> leftHeld=0, go IDLE.
  - RIGHT_CODE -> rightHeld=0, go IDLE.
  - E0 or F0 -> stay EXT_BRK.
  - Any other byte -> IDLE, no flag change.
- Non-extended 6B/74 (no E0 prefix) is keypad 4/6 and never affects Left/Right.
- Typematic repeats (a make code for a key already held) leave every flag and lastDir unchanged.
- lastDir updates only on a 0->1 transition of leftHeld (sets LEFT) or rightHeld (sets RIGHT).
- Output equations, registered one cycle after the flags:
  - Left = leftHeld & (~rightHeld | lastDir==LEFT).
  - Right = rightHeld & (~leftHeld | lastDir==RIGHT).
  - Turbo = turboHeld.
- Latency: a completing byte with dinValid high in cycle N updates the flag at edge N+1 and the output at edge N+2. Total latency is 2 clk.
- Prefix timeout:
  - 16-bit counter, cleared on every dinValid and whenever the FSM is in IDLE.
  - Increments each cycle the FSM is not in IDLE and dinValid=0.
  - When it reaches PREFIX_TIMEOUT-1 the FSM returns to IDLE on the next edge; flags are unchanged.
  - A dinValid arriving in that same cycle is processed normally and takes precedence over the timeout.
- Release of the priority key while both are held: the other direction asserts 2 clk after the break byte.

Test Plan:
- Reset, then E0,6B (one strobe each, 3 idle cycles apart) -> Left=1 two clk after the 6B strobe; Right=0, Turbo=0, prefixState=0.
- Holding left: E0,74 -> Left drops to 0 and Right goes to 1 (last-pressed wins). Then E0,F0,74 -> Right=0 and Left=1 again, 2 clk after the 74.
- Holding both with right last: send E0,6B (repeat of left) -> outputs unchanged (Right=1, Left=0), lastDir unchanged.
- 29 -> Turbo=1. Then F0,29 -> Turbo=0. Then bare 6B, then bare 74 -> Left and Right stay 0.
- PREFIX_TIMEOUT=20: send E0, wait 25 cycles, send 6B -> prefixState back at 0 by cycle 20, Left stays 0. Repeat with 6B sent at cycle 19 after E0 -> Left=1.
- Assert reset for 1 cycle while in EXT_BRK with Left=1 -> all outputs and prefixState 0 on the next edge. A following 6B alone -> no change.
